// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 32-bit reads and hands instructions to decode
// through a registered output stage backed by a one-entry skid buffer.
module fetch_stage #(
  parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  typedef enum logic [1:0] {StRun, StDrain, StFault} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] drain_addr_q;
  logic        fault_done_q;

  logic        out_valid_q;
  logic [63:0] out_pc_q;
  logic [31:0] out_instr_q;
  logic        out_mis_q;

  logic        skid_valid_q;
  logic [63:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic        skid_mis_q;

  logic pc_aligned;
  logic req_done;
  logic out_drain;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign req_done   = ireq_valid & iresp_data_ok;
  assign out_drain  = out_valid_q & out_ready;

  // In DRAIN the stale address must stay on the bus even though pc already holds the target.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc_q;
    case (state_q)
      StRun:   ireq_valid = !skid_valid_q && pc_aligned;
      StDrain: begin
        ireq_valid = 1'b1;
        ireq_addr  = drain_addr_q;
      end
      default: ireq_valid = 1'b0;
    endcase
    if (reset) ireq_valid = 1'b0;
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_instr    = out_instr_q;
  assign out_misalign = out_mis_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= PCINIT;
      drain_addr_q <= 64'd0;
      fault_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 64'd0;
      out_instr_q  <= 32'd0;
      out_mis_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 64'd0;
      skid_instr_q <= 32'd0;
      skid_mis_q   <= 1'b0;
    end else if (redirect_valid) begin
      pc_q         <= redirect_pc;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      fault_done_q <= 1'b0;
      if (ireq_valid && !iresp_data_ok) begin
        state_q      <= StDrain;
        drain_addr_q <= ireq_addr;
      end else begin
        state_q <= (redirect_pc[1:0] != 2'b00) ? StFault : StRun;
      end
    end else begin
      if (out_drain) begin
        if (skid_valid_q) begin
          out_pc_q     <= skid_pc_q;
          out_instr_q  <= skid_instr_q;
          out_mis_q    <= skid_mis_q;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      case (state_q)
        StRun: begin
          if (!pc_aligned) begin
            state_q      <= StFault;
            fault_done_q <= 1'b0;
          end else if (req_done) begin
            // A completing request implies the skid is empty, so ordering is preserved.
            if (!out_valid_q || out_drain) begin
              out_valid_q <= 1'b1;
              out_pc_q    <= pc_q;
              out_instr_q <= iresp_data;
              out_mis_q   <= 1'b0;
            end else begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= pc_q;
              skid_instr_q <= iresp_data;
              skid_mis_q   <= 1'b0;
            end
            pc_q <= pc_q + 64'd4;
          end
        end
        StDrain: begin
          if (iresp_data_ok) begin
            state_q      <= pc_aligned ? StRun : StFault;
            fault_done_q <= 1'b0;
          end
        end
        StFault: begin
          if (!fault_done_q && !skid_valid_q && (!out_valid_q || out_drain)) begin
            out_valid_q  <= 1'b1;
            out_pc_q     <= pc_q;
            out_instr_q  <= 32'd0;
            out_mis_q    <= 1'b1;
            fault_done_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all checked against a
// queue-based transaction model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  // Model: entries waiting for decode in program order (front is what decode sees).
  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_stale;
  int          m_mode;  // 0 fetching, 1 discarding stale request, 2 faulted
  bit          m_pend;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = 64'h0000_0000_8000_0000;
    m_stale = 64'd0;
    m_mode  = 0;
    m_pend  = 1'b0;
  endtask

  // Called at a negedge: drive inputs, check outputs, advance the model, wait a full cycle.
  task automatic step(input bit dok, input logic [31:0] data, input bit rv,
                      input logic [63:0] rpc, input bit rdy);
    bit          ev;
    logic [63:0] ea;
    ent_t        e;
    iresp_data_ok  = dok;
    iresp_data     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    ev = (m_mode == 0) ? (m_q.size() < 2 && m_pc[1:0] == 2'b00) : (m_mode == 1);
    ea = (m_mode == 1) ? m_stale : m_pc;
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, ev});
    if (ev) chk("ireq_addr", ireq_addr, ea);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", {32'd0, out_instr}, {32'd0, m_q[0].instr});
      chk("out_misalign", {63'd0, out_misalign}, {63'd0, m_q[0].mis});
    end
    if (rv) begin
      m_q.delete();
      if (ev && !dok) begin
        m_mode  = 1;
        m_stale = ea;
      end else begin
        m_mode = (rpc[1:0] != 2'b00) ? 2 : 0;
        m_pend = 1'b1;
      end
      m_pc = rpc;
    end else begin
      if (m_q.size() > 0 && rdy) e = m_q.pop_front();
      case (m_mode)
        0: begin
          if (m_pc[1:0] != 2'b00) begin
            m_mode = 2;
            m_pend = 1'b1;
          end else if (ev && dok) begin
            e.pc = m_pc; e.instr = data; e.mis = 1'b0;
            m_q.push_back(e);
            m_pc = m_pc + 64'd4;
          end
        end
        1: begin
          if (dok) begin
            m_mode = (m_pc[1:0] != 2'b00) ? 2 : 0;
            m_pend = 1'b1;
          end
        end
        default: begin
          if (m_pend && m_q.size() == 0) begin
            e.pc = m_pc; e.instr = 32'd0; e.mis = 1'b1;
            m_q.push_back(e);
            m_pend = 1'b0;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] tgt;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    iresp_data_ok = 1'b0;
    iresp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
    reset = 1'b0;

    // Zero-wait streaming.
    for (int i = 0; i < 5; i++) step(1, 32'h0000_0013, 0, 64'd0, 1);
    // Backpressure fills the skid, then releases in order.
    for (int i = 0; i < 3; i++) step(1, 32'h0000_1013 + i, 0, 64'd0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h0000_2013 + i, 0, 64'd0, 1);
    // Redirect while a request is outstanding; stale word must never appear.
    step(0, 32'h1111_1111, 1, 64'h8000_1000, 1);
    step(0, 32'h2222_2222, 0, 64'd0, 1);
    step(1, 32'hdead_beef, 0, 64'd0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h0000_3000 + i, 0, 64'd0, 1);
    // Redirect coinciding with data_ok.
    step(1, 32'hbad0_bad0, 1, 64'h8000_2000, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h0000_4000 + i, 0, 64'd0, 1);
    // Misaligned target, hold idle, then recover.
    step(1, 32'h5555_5555, 1, 64'h8000_0102, 1);
    for (int i = 0; i < 4; i++) step(i % 2, 32'h6666_6666, 0, 64'd0, i != 1);
    step(0, 32'd0, 1, 64'h8000_0200, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h0000_7000 + i, 0, 64'd0, 1);
    // PC wrap at the top of the address space.
    step(1, 32'd0, 1, 64'hffff_ffff_ffff_fff8, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h0000_8000 + i, 0, 64'd0, 1);
    // Reset while a request is outstanding and an entry is presented.
    step(1, 32'h0000_9000, 1, 64'h8000_3000, 1);
    step(1, 32'h0000_9001, 0, 64'd0, 0);
    step(0, 32'h0000_9002, 0, 64'd0, 0);
    reset = 1'b1;
    #1;
    chk("async_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    model_reset();
    @(negedge clk);
    iresp_data_ok = 1'b1;
    @(negedge clk);
    chk("hold_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 32'h0000_a000 + i, 0, 64'd0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 3) == 0) tgt = tgt + 64'($urandom_range(1, 3));
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 15) == 0, tgt,
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
